// File: rtl/mem_access.sv
// Memory-access pipeline stage: one word load/store per instruction over a req/ack port,
// registered write-back fields toward `write`. Optional macro MEM_TIMEOUT_EN aborts stalled requests.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_write_r,
  input  logic        ex_write_en,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_read_mm,
  input  logic        ex_write_mm,
  input  logic        ex_write_pc,
  input  logic [31:0] ex_jmp_pc,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [4:0]  write_r,
  output logic        write_en,
  output logic [31:0] write_data,
  output logic        write_pc,
  output logic [31:0] jmp_pc,
  output logic        mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_d;

  logic accept, mem_op, misaligned, timeout;

  logic        dm_req_d, dm_we_d;
  logic [31:0] dm_addr_d, dm_wdata_d;
  logic        wb_valid_d, write_en_d, write_pc_d, mem_err_d;
  logic [4:0]  write_r_d;
  logic [31:0] write_data_d, jmp_pc_d;
  logic        lat_load;

  // Write-back fields of the instruction waiting on memory
  logic [4:0]  lat_write_r;
  logic        lat_write_en, lat_write_pc, lat_conflict;
  logic [31:0] lat_alu, lat_jmp_pc;

  assign ex_ready   = (state == IDLE);
  assign accept     = ex_valid & ex_ready;
  assign mem_op     = ex_read_mm | ex_write_mm;
  assign misaligned = mem_op & (ex_alu_result[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt;

  assign timeout = (state == BUSY) && !dm_ack && (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        to_cnt <= '0;
    else if (accept)                   to_cnt <= '0;
    else if (state == BUSY && !dm_ack) to_cnt <= to_cnt + 8'd1;
  end
`else
  // Parameter only matters with the counter; legal values are never 0, so this is constant low.
  assign timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept && mem_op && !misaligned) state_d = BUSY;
      BUSY: if (dm_ack || timeout)               state_d = IDLE;
      default:                                   state_d = IDLE;
    endcase
  end

  always_comb begin
    dm_req_d     = dm_req;
    dm_we_d      = dm_we;
    dm_addr_d    = dm_addr;
    dm_wdata_d   = dm_wdata;
    wb_valid_d   = 1'b0;
    write_en_d   = 1'b0;
    write_pc_d   = 1'b0;
    mem_err_d    = 1'b0;
    write_r_d    = write_r;
    write_data_d = write_data;
    jmp_pc_d     = jmp_pc;
    lat_load     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mem_op && !misaligned) begin
            dm_req_d   = 1'b1;
            dm_we_d    = ex_write_mm;
            dm_addr_d  = ex_alu_result;
            dm_wdata_d = ex_store_data;
            lat_load   = 1'b1;
          end else begin
            wb_valid_d   = 1'b1;
            write_r_d    = ex_write_r;
            write_en_d   = ex_write_en & ~mem_op;
            write_data_d = ex_alu_result;
            write_pc_d   = ex_write_pc;
            jmp_pc_d     = ex_jmp_pc;
            mem_err_d    = misaligned;
          end
        end
      end
      BUSY: begin
        if (dm_ack || timeout) begin
          dm_req_d     = 1'b0;
          wb_valid_d   = 1'b1;
          write_r_d    = lat_write_r;
          write_pc_d   = lat_write_pc;
          jmp_pc_d     = lat_jmp_pc;
          write_en_d   = dm_ack & lat_write_en;
          write_data_d = (dm_ack && !dm_we) ? dm_rdata : lat_alu;
          mem_err_d    = dm_ack ? lat_conflict : 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      wb_valid   <= 1'b0;
      write_r    <= '0;
      write_en   <= 1'b0;
      write_data <= '0;
      write_pc   <= 1'b0;
      jmp_pc     <= '0;
      mem_err    <= 1'b0;
    end else begin
      dm_req     <= dm_req_d;
      dm_we      <= dm_we_d;
      dm_addr    <= dm_addr_d;
      dm_wdata   <= dm_wdata_d;
      wb_valid   <= wb_valid_d;
      write_r    <= write_r_d;
      write_en   <= write_en_d;
      write_data <= write_data_d;
      write_pc   <= write_pc_d;
      jmp_pc     <= jmp_pc_d;
      mem_err    <= mem_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write_r  <= '0;
      lat_write_en <= 1'b0;
      lat_write_pc <= 1'b0;
      lat_conflict <= 1'b0;
      lat_alu      <= '0;
      lat_jmp_pc   <= '0;
    end else if (lat_load) begin
      lat_write_r  <= ex_write_r;
      lat_write_en <= ex_write_en & ~ex_write_mm;
      lat_write_pc <= ex_write_pc;
      lat_conflict <= ex_read_mm & ex_write_mm;
      lat_alu      <= ex_alu_result;
      lat_jmp_pc   <= ex_jmp_pc;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random transactions against a
// transaction-level model. Define MEM_TIMEOUT_EN to also exercise the request timeout.
module tb_mem_access;

  localparam int unsigned TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WMAX = TO - 2;
`else
  localparam int unsigned WMAX = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_write_r;
  logic        ex_write_en, ex_read_mm, ex_write_mm, ex_write_pc;
  logic [31:0] ex_alu_result, ex_store_data, ex_jmp_pc;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, write_en, write_pc, mem_err;
  logic [4:0]  write_r;
  logic [31:0] write_data, jmp_pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] last_wd, last_jpc;
  logic [4:0]  last_r;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_write_r(ex_write_r), .ex_write_en(ex_write_en),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_read_mm(ex_read_mm), .ex_write_mm(ex_write_mm),
    .ex_write_pc(ex_write_pc), .ex_jmp_pc(ex_jmp_pc),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .write_r(write_r), .write_en(write_en),
    .write_data(write_data), .write_pc(write_pc), .jmp_pc(jmp_pc),
    .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_ex();
    ex_write_r    = 5'($urandom);
    ex_write_en   = 1'($urandom);
    ex_alu_result = $urandom;
    ex_store_data = $urandom;
    ex_read_mm    = 1'($urandom);
    ex_write_mm   = 1'($urandom);
    ex_write_pc   = 1'($urandom);
    ex_jmp_pc     = $urandom;
  endtask

  task automatic drive_ex(input logic [31:0] alu, sdata, jpc, input logic [4:0] r,
                          input logic we, rd, wr, wpc);
    ex_valid = 1'b1;  ex_alu_result = alu; ex_store_data = sdata; ex_jmp_pc = jpc;
    ex_write_r = r;   ex_write_en = we;    ex_read_mm = rd;       ex_write_mm = wr;
    ex_write_pc = wpc;
  endtask

  // One instruction from accept to retire; memory acks after nwait wait cycles.
  task automatic run_txn(input logic [31:0] alu, sdata, jpc, rdata, input logic [4:0] r,
                         input logic we, rd, wr, wpc, input int unsigned nwait);
    logic mem, mis, exp_we, exp_err;
    logic [31:0] exp_wd;
    mem = rd | wr;
    mis = mem && (alu[1:0] != 2'b00);
    check("ex_ready_pre", ex_ready, 1);
    drive_ex(alu, sdata, jpc, r, we, rd, wr, wpc);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    scramble_ex();
    if (mem && !mis) begin
      for (int unsigned k = 0; k <= nwait; k++) begin
        check("dm_req_busy", dm_req, 1);
        check("dm_we", dm_we, wr);
        check("dm_addr", dm_addr, alu);
        if (wr) check("dm_wdata", dm_wdata, sdata);
        check("ex_ready_busy", ex_ready, 0);
        check("wb_valid_busy", wb_valid, 0);
        if (k == nwait) begin
          dm_ack = 1'b1; dm_rdata = rdata;
        end else begin
          dm_rdata = $urandom;
        end
        @(posedge clk); #1;
      end
      dm_ack  = 1'b0;
      exp_wd  = wr ? alu : rdata;
      exp_we  = we & ~wr;
      exp_err = rd & wr;
    end else begin
      exp_wd  = alu;
      exp_we  = we & ~mem;
      exp_err = mis;
    end
    check("dm_req_retire", dm_req, 0);
    check("wb_valid", wb_valid, 1);
    check("write_en", write_en, exp_we);
    check("write_data", write_data, exp_wd);
    check("write_r", write_r, r);
    check("write_pc", write_pc, wpc);
    check("jmp_pc", jmp_pc, jpc);
    check("mem_err", mem_err, exp_err);
    check("ex_ready_retire", ex_ready, 1);
    last_wd = exp_wd; last_r = r; last_jpc = jpc;
  endtask

  // No instruction offered; a stray ack must be ignored and data fields hold.
  task automatic idle_cycle(input logic stray_ack);
    dm_ack = stray_ack;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    check("idle_wb_valid", wb_valid, 0);
    check("idle_write_en", write_en, 0);
    check("idle_write_pc", write_pc, 0);
    check("idle_mem_err", mem_err, 0);
    check("idle_dm_req", dm_req, 0);
    check("idle_ex_ready", ex_ready, 1);
    check("hold_write_data", write_data, last_wd);
    check("hold_write_r", write_r, last_r);
    check("hold_jmp_pc", jmp_pc, last_jpc);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    scramble_ex();
    last_wd = '0; last_r = '0; last_jpc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_ready", ex_ready, 1);
    check("rst_dm_req", dm_req, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_write_en", write_en, 0);
    check("rst_write_pc", write_pc, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_write_data", write_data, 0);
    check("rst_write_r", write_r, 0);
    check("rst_jmp_pc", jmp_pc, 0);
    rst_n = 1'b1;
    idle_cycle(1'b1);

    run_txn(32'h0000_1234, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_txn(32'h0000_0100, 32'h0, 32'h40, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    run_txn(32'h0000_0200, 32'hA5A5_A5A5, 32'h0, 32'h1111_2222, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_txn(32'h0000_0102, 32'h0, 32'h0000_0888, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    run_txn(32'h0000_0304, 32'h5A5A_0F0F, 32'h0, 32'h7777_7777, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    idle_cycle(1'b0);

    // Reset during the second BUSY cycle abandons the request.
    drive_ex(32'h0000_0400, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_before_rst", dm_req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_dm_req", dm_req, 0);
    check("rst_async_ex_ready", ex_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_wd = '0; last_r = '0; last_jpc = '0;
    idle_cycle(1'b0);

`ifdef MEM_TIMEOUT_EN
    drive_ex(32'h0000_0800, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int unsigned k = 0; k < TO; k++) begin
      check("to_dm_req", dm_req, 1);
      @(posedge clk); #1;
    end
    check("to_dm_req_drop", dm_req, 0);
    check("to_wb_valid", wb_valid, 1);
    check("to_write_en", write_en, 0);
    check("to_mem_err", mem_err, 1);
    check("to_ex_ready", ex_ready, 1);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [31:0] alu;
      logic rd, wr;
      int unsigned kind;
      kind = $urandom_range(0, 3);
      rd   = (kind == 1) || (kind == 3);
      wr   = (kind == 2) || (kind == 3);
      alu  = $urandom;
      if ((rd || wr) && ($urandom_range(0, 7) != 0)) alu[1:0] = 2'b00;
      run_txn(alu, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), rd, wr,
              1'($urandom), $urandom_range(0, WMAX));
      if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
